// File: rtl/ldpc_ber_sweep_sched.sv
// LDPC BER sweep scheduler: walks a table of noise operating points, and for
// each one resets the datapath, runs it until a block/error stopping rule
// fires, drains it and emits one result record on a ready/valid stream.
module ldpc_ber_sweep_sched #(
  parameter  int NUM_POINTS = 8,
  parameter  int SETTLE_W   = 8,
  localparam int PW         = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic                abort,
  input  logic                cfg_wr,
  input  logic [PW-1:0]       cfg_addr,
  input  logic [15:0]         cfg_factor,
  input  logic [7:0]          cfg_offset,
  input  logic [PW:0]         num_points,
  input  logic [63:0]         min_blocks,
  input  logic [63:0]         max_blocks,
  input  logic [63:0]         min_errors,
  input  logic [SETTLE_W-1:0] settle_cycles,
  output logic                data_en,
  output logic                data_sw_resetn,
  output logic [15:0]         data_factor,
  output logic [7:0]          data_offset,
  input  logic [63:0]         finished_blocks,
  input  logic [63:0]         bit_errors,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [PW-1:0]       res_point,
  output logic [63:0]         res_blocks,
  output logic [63:0]         res_errors,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, REPORT} state_t;

  typedef struct packed {
    logic [15:0] factor;
    logic [7:0]  offset;
  } point_cfg_t;

  state_t              state, state_nxt;
  point_cfg_t          tbl [NUM_POINTS];
  logic [PW-1:0]       point, point_nxt;
  logic [PW:0]         npts;
  logic [SETTLE_W-1:0] cnt;
  logic                settle_last, stop, last_point, load_entry, sweep_go;

  // A zero settle length still spends one cycle in LOAD/DRAIN.
  assign settle_last = (settle_cycles == '0) || (cnt == settle_cycles - SETTLE_W'(1));
  assign stop        = (finished_blocks >= max_blocks) ||
                       ((finished_blocks >= min_blocks) && (bit_errors >= min_errors));
  assign last_point  = ({1'b0, point} + (PW+1)'(1)) >= npts;
  assign sweep_go    = (state == IDLE) && start && !abort;
  assign load_entry  = (state_nxt == LOAD) && (state != LOAD);

  // Control outputs decode straight from state so an async reset clears them at once;
  // LOAD is the only state with sw reset low and RUN the only one with enable high.
  assign busy           = (state != IDLE);
  assign data_en        = (state == RUN);
  assign data_sw_resetn = (state != LOAD);
  assign res_valid      = (state == REPORT);

  // Next-state logic; abort overrides every transition out of a busy state.
  always_comb begin
    state_nxt = state;
    point_nxt = point;
    case (state)
      IDLE:   if (sweep_go && num_points != '0) begin
                state_nxt = LOAD;
                point_nxt = '0;
              end
      LOAD:   if (settle_last) state_nxt = RUN;
      RUN:    if (stop) state_nxt = DRAIN;
      DRAIN:  if (settle_last) state_nxt = REPORT;
      REPORT: if (res_ready) begin
                if (last_point) state_nxt = IDLE;
                else begin
                  state_nxt = LOAD;
                  point_nxt = point + PW'(1);
                end
              end
      default: state_nxt = IDLE;
    endcase
    if (abort && state != IDLE) state_nxt = IDLE;
  end

  // State, point index and the settle/drain cycle counter (restarts on every state change).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      point <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      point <= point_nxt;
      if (state_nxt != state) cnt <= '0;
      else                    cnt <= cnt + SETTLE_W'(1);
    end
  end

  // Operating-point table; host writes land only while idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_POINTS; i++) tbl[i] <= '0;
    end else if (cfg_wr && state == IDLE && int'(cfg_addr) < NUM_POINTS) begin
      tbl[cfg_addr] <= '{factor: cfg_factor, offset: cfg_offset};
    end
  end

  // Sweep length is clamped to the table depth and frozen at start.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                        npts <= '0;
    else if (sweep_go) begin
      if (int'(num_points) > NUM_POINTS) npts <= (PW+1)'(NUM_POINTS);
      else                               npts <= num_points;
    end
  end

  // Point configuration is sampled once on entry to LOAD and held through the point.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_factor <= '0;
      data_offset <= '0;
    end else if (load_entry) begin
      data_factor <= tbl[point_nxt].factor;
      data_offset <= tbl[point_nxt].offset;
    end
  end

  // Result record is captured on the last drain cycle and held through REPORT.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      res_point  <= '0;
      res_blocks <= '0;
      res_errors <= '0;
    end else if (state == DRAIN && state_nxt == REPORT) begin
      res_point  <= point;
      res_blocks <= finished_blocks;
      res_errors <= bit_errors;
    end
  end

  // Completion pulse: empty sweep, or final record accepted without abort.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) done <= 1'b0;
    else         done <= (sweep_go && num_points == '0) ||
                         (state == REPORT && res_ready && last_point && !abort);
  end

endmodule

// File: tb/tb_ldpc_ber_sweep_sched.sv
// Bench for ldpc_ber_sweep_sched: a toy datapath counts blocks/errors while
// enabled; each sweep is walked phase by phase against expected lengths and records.
module tb_ldpc_ber_sweep_sched;
  localparam int NP = 8;
  localparam int PW = 3;
  localparam int SW = 8;

  logic          clk = 1'b0, resetn = 1'b0, start = 1'b0, abort = 1'b0, cfg_wr = 1'b0;
  logic [PW-1:0] cfg_addr = '0;
  logic [15:0]   cfg_factor = '0;
  logic [7:0]    cfg_offset = '0;
  logic [PW:0]   num_points = '0;
  logic [63:0]   min_blocks = '0, max_blocks = '0, min_errors = '0;
  logic [SW-1:0] settle_cycles = '0;
  logic          data_en, data_sw_resetn, res_valid, busy, done;
  logic          res_ready = 1'b1;
  logic [15:0]   data_factor;
  logic [7:0]    data_offset;
  logic [63:0]   finished_blocks, bit_errors, res_blocks, res_errors;
  logic [PW-1:0] res_point;

  logic [63:0]   fb_cnt;
  int            err_inc = 0;
  int            tests = 0, fails = 0;
  logic [15:0]   sh_f [NP];
  logic [7:0]    sh_o [NP];

  typedef struct {
    int          np;
    logic [63:0] mx, mn, me;
    int          inc, st, bp;
    logic [63:0] ek, ee;
  } vec_t;
  vec_t vecs [6];

  ldpc_ber_sweep_sched #(.NUM_POINTS(NP), .SETTLE_W(SW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_factor(cfg_factor), .cfg_offset(cfg_offset),
    .num_points(num_points), .min_blocks(min_blocks), .max_blocks(max_blocks),
    .min_errors(min_errors), .settle_cycles(settle_cycles),
    .data_en(data_en), .data_sw_resetn(data_sw_resetn),
    .data_factor(data_factor), .data_offset(data_offset),
    .finished_blocks(finished_blocks), .bit_errors(bit_errors),
    .res_valid(res_valid), .res_ready(res_ready), .res_point(res_point),
    .res_blocks(res_blocks), .res_errors(res_errors), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Toy datapath: one block per enabled cycle (visible in that cycle), errors = blocks*inc/2.
  always @(posedge clk or negedge resetn) begin
    if (!resetn)              fb_cnt <= '0;
    else if (!data_sw_resetn) fb_cnt <= '0;
    else if (data_en)         fb_cnt <= fb_cnt + 64'd1;
  end
  assign finished_blocks = fb_cnt + {63'd0, data_en};
  assign bit_errors      = (finished_blocks * 64'(err_inc)) >> 1;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic write_tbl(input int a, input logic [15:0] f, input logic [7:0] o, input bit upd);
    cfg_wr = 1'b1; cfg_addr = PW'(a); cfg_factor = f; cfg_offset = o;
    tick();
    cfg_wr = 1'b0;
    if (upd) begin sh_f[a] = f; sh_o[a] = o; end
  endtask

  // Stopping rule evaluated directly: first block count k>=1 at which it holds.
  function automatic void model(input logic [63:0] mx, mn, me, input int inc,
                                output logic [63:0] k, e);
    k = 64'd1;
    e = (k * 64'(inc)) >> 1;
    while (!(k >= mx || (k >= mn && e >= me))) begin
      k = k + 64'd1;
      e = (k * 64'(inc)) >> 1;
    end
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"},     64'(data_en), 64'd0);
    check({tag, "_swrst"},  64'(data_sw_resetn), 64'd1);
    check({tag, "_factor"}, 64'(data_factor), 64'd0);
    check({tag, "_offset"}, 64'(data_offset), 64'd0);
    check({tag, "_valid"},  64'(res_valid), 64'd0);
    check({tag, "_rpoint"}, 64'(res_point), 64'd0);
    check({tag, "_rblk"},   res_blocks, 64'd0);
    check({tag, "_rerr"},   res_errors, 64'd0);
    check({tag, "_busy"},   64'(busy), 64'd0);
    check({tag, "_done"},   64'(done), 64'd0);
  endtask

  task automatic sweep(input int np, input logic [63:0] mx, mn, me, input int inc,
                       input int st, input int bp, input logic [63:0] ek, ee);
    int enp, se, n;
    bit en_in_rst, stable;
    logic [PW-1:0] hp;
    logic [63:0] hb, he;
    enp = (np > NP) ? NP : np;
    se  = (st == 0) ? 1 : st;
    num_points = (PW+1)'(np); max_blocks = mx; min_blocks = mn; min_errors = me;
    err_inc = inc; settle_cycles = SW'(st);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    for (int p = 0; p < enp; p++) begin
      n = 0;
      while (data_sw_resetn && n < 50) begin tick(); n++; end
      if (n >= 50) begin check("load_timeout", 64'd1, 64'd0); return; end
      check("factor", 64'(data_factor), 64'(sh_f[p]));
      check("offset", 64'(data_offset), 64'(sh_o[p]));
      n = 0; en_in_rst = 1'b0;
      while (!data_sw_resetn && n < 300) begin en_in_rst |= data_en; n++; tick(); end
      check("rst_len", 64'(n), 64'(se));
      check("en_during_rst", 64'(en_in_rst), 64'd0);
      n = 0;
      while (data_en && n < 3000) begin n++; tick(); end
      check("run_len", 64'(n), ek);
      n = 0;
      while (!res_valid && n < 300) begin n++; tick(); end
      check("drain_len", 64'(n), 64'(se));
      check("res_point", 64'(res_point), 64'(p));
      check("res_blocks", res_blocks, ek);
      check("res_errors", res_errors, ee);
      if (p == 0 && bp > 0) begin
        res_ready = 1'b0;
        hp = res_point; hb = res_blocks; he = res_errors;
        for (int i = 0; i < bp; i++) begin
          tick();
          stable = (res_valid === 1'b1) && (res_point === hp) &&
                   (res_blocks === hb) && (res_errors === he);
          check("bp_hold", 64'(stable), 64'd1);
          check("bp_no_load", 64'(data_sw_resetn), 64'd1);
        end
        res_ready = 1'b1;
      end
      check("done_before_hs", 64'(done), 64'd0);
      tick();
      check("valid_one_cycle", 64'(res_valid), 64'd0);
      if (p == enp - 1) begin
        check("done_pulse", 64'(done), 64'd1);
        check("busy_clear", 64'(busy), 64'd0);
        tick();
        check("done_once", 64'(done), 64'd0);
      end else begin
        check("done_mid", 64'(done), 64'd0);
      end
    end
  endtask

  initial begin
    int n;
    bit bad;
    logic [63:0] k, e, mx, mn, me;

    vecs[0] = '{np: 3,  mx: 64'd10,   mn: 64'd0, me: '1,      inc: 0, st: 4, bp: 0,  ek: 64'd10, ee: 64'd0};
    vecs[1] = '{np: 1,  mx: 64'd1000, mn: 64'd5, me: 64'd3,   inc: 3, st: 2, bp: 0,  ek: 64'd5,  ee: 64'd7};
    vecs[2] = '{np: 2,  mx: 64'd3,    mn: 64'd0, me: '1,      inc: 2, st: 3, bp: 20, ek: 64'd3,  ee: 64'd3};
    vecs[3] = '{np: 3,  mx: 64'd0,    mn: 64'd7, me: 64'd100, inc: 4, st: 1, bp: 0,  ek: 64'd1,  ee: 64'd2};
    vecs[4] = '{np: 2,  mx: 64'd4,    mn: 64'd2, me: 64'd1,   inc: 1, st: 0, bp: 0,  ek: 64'd2,  ee: 64'd1};
    vecs[5] = '{np: 12, mx: 64'd2,    mn: 64'd50, me: 64'd0,  inc: 5, st: 1, bp: 0,  ek: 64'd2,  ee: 64'd5};

    repeat (3) tick();
    check_reset_outputs("reset");
    resetn = 1'b1;
    tick();

    for (int i = 0; i < NP; i++) write_tbl(i, 16'(100 * (i + 1)), 8'(i + 1), 1'b1);

    // Empty sweep: done one cycle after start, datapath never enabled.
    num_points = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("np0_done", 64'(done), 64'd1);
    check("np0_busy", 64'(busy), 64'd0);
    check("np0_en", 64'(data_en), 64'd0);
    tick();
    check("np0_done_once", 64'(done), 64'd0);

    foreach (vecs[i])
      sweep(vecs[i].np, vecs[i].mx, vecs[i].mn, vecs[i].me, vecs[i].inc,
            vecs[i].st, vecs[i].bp, vecs[i].ek, vecs[i].ee);

    // Abort in point 1 RUN, with a table write attempted mid-run.
    num_points = 3; max_blocks = 64'd40; min_blocks = '0; min_errors = '1;
    err_inc = 0; settle_cycles = 8'd2;
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!res_valid && n < 500) begin tick(); n++; end
    tick();
    n = 0;
    while (!data_en && n < 100) begin tick(); n++; end
    check("abort_p1_factor", 64'(data_factor), 64'(sh_f[1]));
    write_tbl(0, 16'hdead, 8'h5a, 1'b0);
    tick();
    check("abort_still_run", 64'(data_en), 64'd1);
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_en", 64'(data_en), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_swrst", 64'(data_sw_resetn), 64'd1);
    check("abort_valid", 64'(res_valid), 64'd0);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin bad |= done | busy; tick(); end
    check("abort_no_done", 64'(bad), 64'd0);
    sweep(vecs[0].np, vecs[0].mx, vecs[0].mn, vecs[0].me, vecs[0].inc,
          vecs[0].st, vecs[0].bp, vecs[0].ek, vecs[0].ee);

    // Random sweeps against the stopping-rule model.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NP; i++) write_tbl(i, 16'($urandom), 8'($urandom), 1'b1);
      mx = 64'($urandom_range(0, 20));
      mn = 64'($urandom_range(0, 20));
      me = 64'($urandom_range(0, 30));
      err_inc = int'($urandom_range(0, 5));
      model(mx, mn, me, err_inc, k, e);
      sweep(int'($urandom_range(1, 4)), mx, mn, me, err_inc, int'($urandom_range(0, 5)),
            (r % 2 == 1) ? int'($urandom_range(1, 5)) : 0, k, e);
    end

    // Asynchronous reset in the middle of DRAIN, away from any clock edge.
    num_points = 2; max_blocks = 64'd5; min_errors = '1; err_inc = 0; settle_cycles = 8'd6;
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!data_en && n < 100) begin tick(); n++; end
    n = 0;
    while (data_en && n < 100) begin tick(); n++; end
    tick();
    #2 resetn = 1'b0;
    #1 check_reset_outputs("async");
    tick();
    resetn = 1'b1;
    for (int i = 0; i < NP; i++) begin sh_f[i] = '0; sh_o[i] = '0; end
    sweep(2, 64'd1, 64'd0, '1, 0, 1, 0, 64'd1, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ldpc_ber_sweep_sched.md
Name: ldpc_ber_sweep_sched

Overview:
- Sequences the LDPC BER tester datapath through a programmed sweep of noise operating points (factor/offset pairs) without per-point host intervention.
- For each point it:
  - loads the point's configuration;
  - pulses the datapath software reset;
  - enables noise generation until a block-count or error-count stopping rule is met;
  - drains in-flight frames;
  - emits one result record on a ready/valid stream.
- Sits between the register map and the grng/ctrl/ber_counter datapath, in the data clock domain.

Parameters:
- NUM_POINTS, 8, depth of the operating-point table; index width PW = clog2(NUM_POINTS).
- SETTLE_W, 8, width of the settle/drain cycle counters.

Ports:
- clk  in  1  data clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  single-cycle sweep start pulse
- abort  in  1  single-cycle abort pulse
- cfg_wr  in  1  table write strobe
- cfg_addr  in  PW  table write index
- cfg_factor  in  16  factor written to table entry
- cfg_offset  in  8  offset written to table entry
- num_points  in  PW+1  number of points to sweep, entries 0..num_points-1
- min_blocks  in  64  minimum finished blocks before the error rule may stop a point
- max_blocks  in  64  finished-block limit that always stops a point
- min_errors  in  64  bit-error target
- settle_cycles  in  SETTLE_W  reset-hold length and drain length
- data_en  out  1  datapath noise enable
- data_sw_resetn  out  1  datapath software reset, active-low
- data_factor  out  16  current point factor
- data_offset  out  8  current point offset
- finished_blocks  in  64  datapath finished-block count
- bit_errors  in  64  datapath bit-error count
- res_valid  out  1  result record valid
- res_ready  in  1  result record accept
- res_point  out  PW  point index of the record
- res_blocks  out  64  captured finished_blocks
- res_errors  out  64  captured bit_errors
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at sweep completion

Behaviour:
- Reset values: data_en=0, data_sw_resetn=1, data_factor=0, data_offset=0, res_valid=0, res_point=0, res_blocks=0, res_errors=0, busy=0, done=0, state=IDLE, point index=0. Table contents are also reset to 0.
- Table writes:
  - cfg_wr writes entry cfg_addr only while state==IDLE; writes in any other state are ignored.
  - cfg_addr >= NUM_POINTS is ignored.
- IDLE:
  - On start with num_points==0: done pulses the next cycle and the state stays IDLE.
  - On start with num_points>0: point=0, go to LOAD; busy rises the cycle after start.
  - num_points > NUM_POINTS is clamped to NUM_POINTS, latched at start.
- LOAD:
  - data_factor/data_offset are registered from table[point] on entry and held until the next LOAD.
  - data_sw_resetn=0 and data_en=0 for max(settle_cycles,1) cycles, then go to RUN.
- RUN:
  - data_sw_resetn=1, data_en=1.
  - Each cycle, evaluate stop = (finished_blocks >= max_blocks) OR (finished_blocks >= min_blocks AND bit_errors >= min_errors). All comparisons are unsigned 64-bit.
  - When stop is true, go to DRAIN.
  - max_blocks=0 stops on the first RUN cycle.
- DRAIN:
  - data_en=0 for max(settle_cycles,1) cycles.
  - On exit, latch res_point=point, res_blocks=finished_blocks, res_errors=bit_errors, and go to REPORT.
- REPORT:
  - res_valid=1; record fields are stable while res_valid && !res_ready.
  - On res_valid && res_ready, clear res_valid.
  - If point+1 < latched num_points: increment point and go to LOAD. Otherwise pulse done, clear busy, go to IDLE.
  - With res_ready tied high, a record occupies exactly one cycle.
- abort (any state other than IDLE): next cycle, data_en=0, data_sw_resetn=1, res_valid=0, busy=0, state=IDLE; done is not pulsed.
- abort has priority over start and over every state transition in the same cycle.
- start while busy is ignored.
- busy is 1 in LOAD, RUN, DRAIN and REPORT.
- data_en is never 1 while data_sw_resetn is 0.

Test Plan:
- Table entries 0..2 = (100,1), (200,2), (300,3); num_points=3; max_blocks=10; min_errors=2^64-1; settle_cycles=4; finished_blocks ramps +1 per RUN cycle, reset by sw_resetn.
  - Required: 3 records with res_point 0, 1, 2 and res_blocks=10 each.
  - Required: data_sw_resetn low exactly 4 cycles per point; data_factor = 100, 200, 300 in order.
  - Required: done pulses once, after the third handshake.
- Error rule: min_blocks=5, min_errors=3, max_blocks=1000; bit_errors reaches 3 at finished_blocks=2.
  - Required: RUN continues until finished_blocks=5, then DRAIN; res_errors >= 3.
- Backpressure: res_ready held low for 20 cycles in REPORT.
  - Required: res_valid stays high, fields stay stable, and LOAD of the next point starts only after the handshake.
- Abort mid-RUN at point 1.
  - Required: next cycle data_en=0, busy=0, no done pulse.
  - Required: a new start restarts at point 0.
- Configuration corner cases:
  - Required: num_points=0 gives a done pulse one cycle after start, with data_en never asserted.
  - Required: cfg_wr during RUN leaves the table unchanged (verified by a subsequent sweep).
  - Required: max_blocks=0 gives exactly one RUN cycle per point.
- Asynchronous resetn asserted mid-DRAIN.
  - Required: all outputs immediately return to their reset values, independent of clk.
